alu_muldiv_ctrl: RTL and testbench

Next-generation ALU control for the MIPS EX stage. It has two parts. The first decodes `alu_opcode`/`funct` into a 4-bit `AluControl` with a full 6-bit `funct` decode. The second owns a WIDTH-parametrised iterative multiply/divide engine with HI/LO registers. The block issues pipeline stalls for MFHI/MFLO or a new MULT/DIV while the engine is busy, so the core can add MULT[U]/DIV[U]/MFHI/MFLO without a combinational multiplier.

---
 rtl/alu_muldiv_ctrl_if.sv | 23 ++
 rtl/alu_muldiv_ctrl.sv | 178 +++++++++++++++++
 tb/tb_alu_muldiv_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_muldiv_ctrl_if.sv
// EX-stage bus for alu_muldiv_ctrl: decode inputs, mul/div operands, stall and HI/LO read-back.
// The master drives the instruction fields; the slave returns control, busy, stall and mf_result.
interface alu_muldiv_ctrl_if #(parameter int WIDTH = 32);
  logic [1:0]       alu_opcode;
  logic [5:0]       funct;
  logic             issue;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [3:0]       AluControl;
  logic             md_busy;
  logic             stall;
  logic [WIDTH-1:0] mf_result;

  modport master (
    output alu_opcode, funct, issue, src_a, src_b,
    input  AluControl, md_busy, stall, mf_result
  );

  modport slave (
    input  alu_opcode, funct, issue, src_a, src_b,
    output AluControl, md_busy, stall, mf_result
  );
endinterface

// File: rtl/alu_muldiv_ctrl.sv
// ALU control decode (0 latency) plus iterative MULT/DIV engine with HI/LO (WIDTH+2 cycles issue to result);
// stalls MFHI/MFLO and new mul/div ops while busy. The engine is built only when ALU_MULDIV_EN is defined.
module alu_muldiv_ctrl #(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  alu_muldiv_ctrl_if.slave bus
);

  logic [3:0] w_alu_ctrl;

  always_comb begin
    w_alu_ctrl = 4'b0010;
    case (bus.alu_opcode)
      2'b01: w_alu_ctrl = 4'b0110;
      2'b11: w_alu_ctrl = 4'b0001;
      2'b10: begin
        case (bus.funct)
          6'b100000, 6'b100001: w_alu_ctrl = 4'b0010;
          6'b100010, 6'b100011: w_alu_ctrl = 4'b0110;
          6'b100100:            w_alu_ctrl = 4'b0000;
          6'b100101:            w_alu_ctrl = 4'b0001;
          6'b100110:            w_alu_ctrl = 4'b0011;
          6'b100111:            w_alu_ctrl = 4'b1100;
          6'b101010:            w_alu_ctrl = 4'b0111;
          6'b101011:            w_alu_ctrl = 4'b1111;
          default:              w_alu_ctrl = 4'b0010;
        endcase
      end
      default: w_alu_ctrl = 4'b0010;
    endcase
  end

  assign bus.AluControl = w_alu_ctrl;

`ifdef ALU_MULDIV_EN
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

  localparam int CW = $clog2(WIDTH);

  state_t             r_state;
  state_t             w_next;
  logic [CW-1:0]      r_cnt;
  logic [2*WIDTH-1:0] r_p;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_is_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_div0;
  logic               r_busy;

  logic               w_is_md;
  logic               w_is_mf;
  logic               w_start;
  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_last;

  assign w_is_md  = (bus.alu_opcode == 2'b10) && (bus.funct[5:2] == 4'b0110);
  assign w_is_mf  = (bus.alu_opcode == 2'b10) &&
                    ((bus.funct == 6'b010000) || (bus.funct == 6'b010010));
  assign w_start  = (r_state == S_IDLE) && bus.issue && w_is_md;
  assign w_signed = ~bus.funct[0];
  assign w_a_neg  = w_signed & bus.src_a[WIDTH-1];
  assign w_b_neg  = w_signed & bus.src_b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? (~bus.src_a + 1'b1) : bus.src_a;
  assign w_b_mag  = w_b_neg ? (~bus.src_b + 1'b1) : bus.src_b;
  assign w_last   = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_next = S_RUN;
      S_RUN:   if (w_last)  w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Multiply: r_p = {partial, multiplier}, add multiplicand on LSB then shift right.
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;
  assign w_mul_sum  = {1'b0, r_p[2*WIDTH-1:WIDTH]} + {1'b0, (r_p[0] ? r_b : {WIDTH{1'b0}})};
  assign w_mul_next = {w_mul_sum, r_p[WIDTH-1:1]};

  // Divide: r_p = {remainder, dividend/quotient}, restoring subtract one bit per step.
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_rem_diff;
  logic               w_q_bit;
  logic [2*WIDTH-1:0] w_div_next;
  assign w_rem_sh   = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
  assign w_rem_diff = w_rem_sh - {1'b0, r_b};
  assign w_q_bit    = (w_rem_sh >= {1'b0, r_b});
  assign w_div_next = {(w_q_bit ? w_rem_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0]),
                       r_p[WIDTH-2:0], w_q_bit};

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;
  assign w_prod = r_neg_q ? (~r_p + 1'b1) : r_p;
  assign w_quot = r_div0 ? {WIDTH{1'b1}} :
                  (r_neg_q ? (~r_p[WIDTH-1:0] + 1'b1) : r_p[WIDTH-1:0]);
  // Divide-by-zero leaves |dividend| in the remainder, so the sign fix restores src_a.
  assign w_rem  = r_neg_r ? (~r_p[2*WIDTH-1:WIDTH] + 1'b1) : r_p[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_p      <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_busy <= (w_next != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_cnt    <= '0;
            r_is_div <= bus.funct[1];
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            r_div0   <= bus.funct[1] && (bus.src_b == '0);
            if (bus.funct[1]) begin
              r_p <= {{WIDTH{1'b0}}, w_a_mag};
              r_b <= w_b_mag;
            end else begin
              r_p <= {{WIDTH{1'b0}}, w_b_mag};
              r_b <= w_a_mag;
            end
          end
        end
        S_RUN: begin
          r_p   <= r_is_div ? w_div_next : w_mul_next;
          r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
        S_FIX: begin
          if (r_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quot;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.md_busy   = r_busy;
  assign bus.stall     = bus.issue & r_busy & (w_is_md | w_is_mf);
  assign bus.mf_result = (bus.funct == 6'b010000) ? r_hi : r_lo;
`else
  assign bus.md_busy   = 1'b0;
  assign bus.stall     = 1'b0;
  assign bus.mf_result = '0;
`endif

endmodule

// File: tb/tb_alu_muldiv_ctrl.sv
// Scoreboarded bench for alu_muldiv_ctrl: driver pushes expected decode/HI/LO values, a negedge monitor compares.
// Covers both builds (ALU_MULDIV_EN defined or not) via the EN constant.
module tb_alu_muldiv_ctrl;
  localparam int W = 32;
`ifdef ALU_MULDIV_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_muldiv_ctrl_if #(.WIDTH(W)) bus ();
  alu_muldiv_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [3:0]   ctrl;
    bit           is_mf;
    logic [W-1:0] mf;
  } exp_t;

  exp_t         sb_q[$];
  int           tests = 0;
  int           fails = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [3:0] exp_ctrl(input logic [1:0] opc, input logic [5:0] f);
    if (opc == 2'b00) return 4'b0010;
    if (opc == 2'b01) return 4'b0110;
    if (opc == 2'b11) return 4'b0001;
    case (f)
      6'b100000, 6'b100001, 6'b100010 - 6'd2: return 4'b0010;
      6'b100010, 6'b100011: return 4'b0110;
      6'b100100: return 4'b0000;
      6'b100101: return 4'b0001;
      6'b100110: return 4'b0011;
      6'b100111: return 4'b1100;
      6'b101010: return 4'b0111;
      6'b101011: return 4'b1111;
      default:   return 4'b0010;
    endcase
  endfunction

  function automatic bit is_md(input logic [1:0] opc, input logic [5:0] f);
    return (opc == 2'b10) && (f == F_MULT || f == F_MULTU || f == F_DIV || f == F_DIVU);
  endfunction

  // Reference: HI/LO as seen by the next MFHI/MFLO, from plain integer arithmetic.
  task automatic model_md(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    longint      x, y, q, r;
    logic [63:0] p;
    if (!EN) return;
    case (f)
      F_MULT: begin
        x = longint'($signed(a)); y = longint'($signed(b));
        p = 64'(x * y);
        m_hi = p[63:32]; m_lo = p[31:0];
      end
      F_MULTU: begin
        p = 64'(a) * 64'(b);
        m_hi = p[63:32]; m_lo = p[31:0];
      end
      F_DIV: begin
        if (b == 0) begin
          m_hi = a; m_lo = '1;
        end else begin
          x = longint'($signed(a)); y = longint'($signed(b));
          q = x / y; r = x % y;
          m_lo = q[31:0]; m_hi = r[31:0];
        end
      end
      default: begin
        if (b == 0) begin
          m_hi = a; m_lo = '1;
        end else begin
          m_lo = a / b; m_hi = a % b;
        end
      end
    endcase
  endtask

  task automatic do_op(input logic [1:0] opc, input logic [5:0] f, input logic [W-1:0] a,
                       input logic [W-1:0] b, output int stalls, input bit no_sync = 1'b0);
    exp_t e;
    if (!no_sync) begin
      @(posedge clk); #1;
    end
    bus.alu_opcode = opc; bus.funct = f; bus.src_a = a; bus.src_b = b; bus.issue = 1'b1;
    e.ctrl  = exp_ctrl(opc, f);
    e.is_mf = (opc == 2'b10) && (f == F_MFHI || f == F_MFLO);
    e.mf    = (f == F_MFHI) ? m_hi : m_lo;
    sb_q.push_back(e);
    if (is_md(opc, f)) model_md(f, a, b);
    stalls = 0;
    @(negedge clk);
    while (bus.stall === 1'b1 && stalls < 200) begin
      stalls++;
      @(negedge clk);
    end
    if (stalls >= 200) begin
      tests++; fails++;
      $display("FAIL stall_timeout: got stall for %0d cycles, expected release", stalls);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bus.issue = 1'b0;
    end
  endtask

  task automatic md_and_read(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
    int st;
    do_op(2'b10, f, a, b, st);
    do_op(2'b10, F_MFHI, '0, '0, st);
    do_op(2'b10, F_MFLO, '0, '0, st);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.issue && !bus.stall) begin
        if (sb_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL scoreboard_empty: got an accepted instruction, expected none");
        end else begin
          e = sb_q.pop_front();
          check("alu_control", 64'(bus.AluControl), 64'(e.ctrl));
          if (e.is_mf) check("mf_result", 64'(bus.mf_result), 64'(e.mf));
        end
      end
    end
  end

  initial begin : driver
    int st, busy_cnt, first_busy;
    logic [1:0] opc;
    logic [5:0] f;
    logic [W-1:0] a, b;
    rst = 1'b1;
    bus.issue = 1'b0; bus.alu_opcode = '0; bus.funct = '0; bus.src_a = '0; bus.src_b = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("busy_after_reset", 64'(bus.md_busy), 64'(0));
    do_op(2'b10, F_MFLO, '0, '0, st);
    check("mflo_stall_after_reset", 64'(st), 64'(0));

    // Decode sweep
    do_op(2'b10, 6'b100111, '0, '0, st);
    do_op(2'b10, 6'b101011, '0, '0, st);
    do_op(2'b00, 6'($urandom), '0, '0, st);
    do_op(2'b11, 6'($urandom), '0, '0, st);
    do_op(2'b01, 6'($urandom), '0, '0, st);
    do_op(2'b10, 6'b111111, '0, '0, st);
    for (int i = 0; i < 64; i++) do_op(2'b10, 6'(i), '0, '0, st);
    idle(W + 4);

    // MULT -3*7: busy window and same-cycle-free read-back
    do_op(2'b10, F_MULT, 32'hFFFF_FFFD, 32'd7, st);
    busy_cnt = 0; first_busy = 0;
    for (int c = 1; c <= W + 1; c++) begin
      idle(1);
      @(negedge clk);
      if (bus.md_busy === 1'b1) begin
        busy_cnt++;
        if (first_busy == 0) first_busy = c;
      end
    end
    check("busy_cycles", 64'(busy_cnt), EN ? 64'(W + 1) : 64'(0));
    check("busy_first_cycle", 64'(first_busy), EN ? 64'(1) : 64'(0));
    do_op(2'b10, F_MFHI, '0, '0, st);
    check("busy_cycle_w2", 64'(bus.md_busy), 64'(0));
    check("mfhi_stall_w2", 64'(st), 64'(0));
    do_op(2'b10, F_MFLO, '0, '0, st);

    // Directed divide / multiply corners
    md_and_read(F_DIVU, 32'd100, 32'd7);
    md_and_read(F_DIV, 32'hFFFF_FFF9, 32'd2);
    md_and_read(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    md_and_read(F_DIV, 32'h1234_5678, 32'd0);
    md_and_read(F_DIVU, 32'h8765_4321, 32'd0);
    md_and_read(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    md_and_read(F_MULT, 32'h8000_0000, 32'h8000_0000);
    md_and_read(F_DIV, 32'h0000_0007, 32'hFFFF_FFFE);

    // Hazard: MULT cycle 0, ADD cycle 3, MFLO from cycle 5
    do_op(2'b10, F_MULT, 32'h0001_2345, 32'hFFFF_0F0F, st);
    idle(2);
    do_op(2'b00, 6'b000000, '0, '0, st);
    check("add_stall_during_busy", 64'(st), 64'(0));
    check("busy_at_add", 64'(bus.md_busy), 64'(EN));
    idle(1);
    do_op(2'b10, F_MFLO, '0, '0, st);
    check("mflo_hazard_stalls", 64'(st), EN ? 64'(29) : 64'(0));

    // Reset in cycle 10 of a MULT, then read HI/LO in cycle 11
    do_op(2'b10, F_MULT, 32'h7654_3210, 32'h0000_1234, st);
    idle(9);
    @(posedge clk); #1;
    rst = 1'b1; bus.issue = 1'b0;
    m_hi = '0; m_lo = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    do_op(2'b10, F_MFHI, '0, '0, st, 1'b1);
    check("busy_after_abort", 64'(bus.md_busy), 64'(0));
    check("mfhi_stall_after_abort", 64'(st), 64'(0));
    do_op(2'b10, F_MFLO, '0, '0, st);

    // Reset in cycle 10, new MULT accepted in cycle 11
    do_op(2'b10, F_MULT, 32'hDEAD_BEEF, 32'h0000_0003, st);
    idle(9);
    @(posedge clk); #1;
    rst = 1'b1; bus.issue = 1'b0;
    m_hi = '0; m_lo = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    do_op(2'b10, F_MULT, 32'h0000_1111, 32'hFFFF_FFF0, st, 1'b1);
    check("mult_stall_after_abort", 64'(st), 64'(0));
    do_op(2'b10, F_MFLO, '0, '0, st);
    check("mflo_stall_after_restart", 64'(st), EN ? 64'(W + 1) : 64'(0));
    do_op(2'b10, F_MFHI, '0, '0, st);

    // Randomized mix
    for (int i = 0; i < 80; i++) begin
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 5))
        0: begin opc = 2'($urandom); f = 6'($urandom); end
        1, 2: begin
          opc = 2'b10; f = 6'b011000 | 6'($urandom_range(0, 3));
          case ($urandom_range(0, 3))
            0: b = '0;
            1: b = 32'($urandom_range(1, 15));
            2: a = -32'($urandom_range(1, 1000));
            default: ;
          endcase
        end
        3: begin opc = 2'b10; f = F_MFHI; end
        4: begin opc = 2'b10; f = F_MFLO; end
        default: begin opc = 2'b10; f = 6'b100000 | 6'($urandom_range(0, 11)); end
      endcase
      do_op(opc, f, a, b, st);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
    end
    do_op(2'b10, F_MFHI, '0, '0, st);
    do_op(2'b10, F_MFLO, '0, '0, st);
    idle(4);
    check("scoreboard_drained", 64'(sb_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
